// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Sequencer and arbiter for a register file write port whose storage has no
//   reset. After reset it sweeps every register to INIT_VALUE. After the sweep
//   it shares the write port between requester A (ALU writeback) and requester
//   B (load writeback) using round-robin valid/ready handshakes.
//
// Ports
//   Clock, Reset          : clock; synchronous active-high reset
//   AValid/ARD/AData      : requester A write request (held until AReady)
//   AReady                : A granted this cycle (combinational)
//   BValid/BRD/BData      : requester B write request (held until BReady)
//   BReady                : B granted this cycle (combinational)
//   RegWrite/RD/WriteData : registered register file write port
//   InitDone              : registered, high once the init sweep has finished
module regfile_write_arbiter #(
   parameter int                    DATA_WIDTH = 16,
   parameter int                    ADDR_WIDTH = 2,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  AValid,
   input  logic [ADDR_WIDTH-1:0] ARD,
   input  logic [DATA_WIDTH-1:0] AData,
   output logic                  AReady,
   input  logic                  BValid,
   input  logic [ADDR_WIDTH-1:0] BRD,
   input  logic [DATA_WIDTH-1:0] BData,
   output logic                  BReady,
   output logic                  RegWrite,
   output logic [ADDR_WIDTH-1:0] RD,
   output logic [DATA_WIDTH-1:0] WriteData,
   output logic                  InitDone
);

   typedef enum logic {
      INIT,
      RUN
   } state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] cnt;
   logic                  prio;   // 0: A favoured on contention, 1: B favoured

   // Grants depend only on the current state and the valids, so a requester
   // sees its ready in the same cycle it raises valid.
   always_comb begin
      AReady = 1'b0;
      BReady = 1'b0;
      if (state == RUN) begin
         AReady = AValid & (~BValid | ~prio);
         BReady = BValid & (~AValid |  prio);
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state     <= INIT;
         cnt       <= '0;
         prio      <= 1'b0;
         RegWrite  <= 1'b0;
         RD        <= '0;
         WriteData <= '0;
         InitDone  <= 1'b0;
      end else begin
         case (state)
            INIT: begin
               RegWrite  <= 1'b1;
               RD        <= cnt;
               WriteData <= INIT_VALUE;
               cnt       <= cnt + 1'b1;   // wraps to 0 after the last register
               if (cnt == '1) begin
                  state    <= RUN;
                  InitDone <= 1'b1;
               end
            end
            RUN: begin
               if (AReady) begin
                  RegWrite  <= 1'b1;
                  RD        <= ARD;
                  WriteData <= AData;
                  prio      <= 1'b1;
               end else if (BReady) begin
                  RegWrite  <= 1'b1;
                  RD        <= BRD;
                  WriteData <= BData;
                  prio      <= 1'b0;
               end else begin
                  // Idle: RD and WriteData hold their last values.
                  RegWrite <= 1'b0;
               end
            end
            default: state <= INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter
//   Directed and randomized bench for regfile_write_arbiter. A small register
//   file array is written from the DUT's write port. An abstract model tracks
//   the remaining init sweep, the favoured requester and the expected register
//   contents. Each step checks readiness before the edge and the write port
//   after it.
module tb_regfile_write_arbiter;

   localparam int          DW   = 16;
   localparam int          AW   = 2;
   localparam int          NREG = 1 << AW;
   localparam logic [DW-1:0] INIT = 16'h0000;

   logic          Clock = 1'b0;
   logic          Reset = 1'b1;
   logic          AValid = 1'b0, BValid = 1'b0;
   logic [AW-1:0] ARD = '0, BRD = '0;
   logic [DW-1:0] AData = '0, BData = '0;
   logic          AReady, BReady, RegWrite, InitDone;
   logic [AW-1:0] RD;
   logic [DW-1:0] WriteData;

   int unsigned tests = 0;
   int unsigned fails = 0;

   regfile_write_arbiter #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .INIT_VALUE(INIT)
   ) dut (
      .Clock(Clock), .Reset(Reset),
      .AValid(AValid), .ARD(ARD), .AData(AData), .AReady(AReady),
      .BValid(BValid), .BRD(BRD), .BData(BData), .BReady(BReady),
      .RegWrite(RegWrite), .RD(RD), .WriteData(WriteData), .InitDone(InitDone)
   );

   always #5 Clock = ~Clock;

   // Register file storage driven by the DUT's write port.
   logic [DW-1:0] rf [NREG];
   always @(posedge Clock) if (RegWrite) rf[RD] <= WriteData;

   // Abstract model state.
   bit            m_known = 0;     // model is valid once a reset edge has occurred
   int            m_sweep = 0;     // init writes still to come
   bit            m_fav_b = 0;     // B wins the next contested cycle
   bit            m_we = 0, m_done = 0;
   logic [AW-1:0] m_rd = '0;
   logic [DW-1:0] m_wd = '0;
   logic [DW-1:0] m_regs [NREG];

   // Last observed grants (sampled just before the edge).
   logic          obs_a, obs_b;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle. Inputs are already set by the caller, and the caller is
   // away from the rising edge.
   task automatic step(input logic rst);
      bit ea, eb;
      Reset = rst;
      #1;
      obs_a = AReady;
      obs_b = BReady;
      ea = 0;
      eb = 0;
      if (m_known && m_sweep == 0) begin
         // Round robin: a lone requester wins, and the favoured one wins contention.
         if (AValid && BValid) begin
            ea = !m_fav_b;
            eb = m_fav_b;
         end else begin
            ea = AValid;
            eb = BValid;
         end
      end
      if (m_known) begin
         chk("a_ready", obs_a, ea);
         chk("b_ready", obs_b, eb);
      end
      @(posedge Clock);
      if (m_known && m_we) m_regs[m_rd] = m_wd;   // register file commits last output
      if (rst) begin
         m_known = 1;
         m_sweep = NREG;
         m_fav_b = 0;
         m_we = 0; m_rd = '0; m_wd = '0; m_done = 0;
      end else if (m_sweep > 0) begin
         m_we = 1;
         m_rd = AW'(NREG - m_sweep);
         m_wd = INIT;
         m_sweep--;
         if (m_sweep == 0) m_done = 1;
      end else if (ea) begin
         m_we = 1; m_rd = ARD; m_wd = AData; m_fav_b = 1;
      end else if (eb) begin
         m_we = 1; m_rd = BRD; m_wd = BData; m_fav_b = 0;
      end else begin
         m_we = 0;
      end
      #1;
      chk("reg_write", RegWrite, m_we);
      chk("init_done", InitDone, m_done);
      if (m_we) begin
         chk("rd", RD, m_rd);
         chk("write_data", WriteData, m_wd);
      end
      @(negedge Clock);
   endtask

   initial begin
      int unsigned steps;

      for (int i = 0; i < NREG; i++) begin
         rf[i] = 'x;
         m_regs[i] = 'x;
      end

      // Reset for 2 cycles; A valid during init must not be granted.
      step(1);
      step(1);
      chk("reset_regwrite", RegWrite, 0);
      chk("reset_initdone", InitDone, 0);
      AValid = 1; ARD = 2'd1; AData = 16'hFFFF;
      for (int i = 0; i < NREG; i++) begin
         step(0);
         chk("init_a_ready", obs_a, 0);
         chk("init_rd_seq", RD, i);
         chk("init_data", WriteData, INIT);
         chk("init_we", RegWrite, 1);
      end
      chk("init_done_after_sweep", InitDone, 1);
      AValid = 0;
      step(0);
      chk("init_cleared_r1", rf[1], INIT);

      // A only: R2 = 0x1234.
      AValid = 1; ARD = 2'd2; AData = 16'h1234;
      step(0);
      chk("a_only_ready", obs_a, 1);
      chk("a_only_rd", RD, 2);
      chk("a_only_data", WriteData, 16'h1234);
      AValid = 0;
      step(0);
      step(0);
      chk("a_only_rf_r2", rf[2], 16'h1234);

      // B only, which leaves A favoured for the contention test.
      BValid = 1; BRD = 2'd3; BData = 16'h0BAD;
      step(0);
      chk("b_only_ready", obs_b, 1);
      BValid = 0;
      step(0);

      // Both valid for 4 cycles: grants alternate A, B, A, B.
      AValid = 1; ARD = 2'd1; AData = 16'hAAAA;
      BValid = 1; BRD = 2'd3; BData = 16'h5555;
      for (int i = 0; i < 4; i++) begin
         step(0);
         chk("alt_a_grant", obs_a, (i % 2) == 0);
         chk("alt_b_grant", obs_b, (i % 2) == 1);
         chk("alt_regwrite", RegWrite, 1);
      end
      AValid = 0; BValid = 0;
      step(0);

      // Same RD (R0) from both: A first, then B; B's data is final.
      AValid = 1; ARD = 2'd0; AData = 16'h0001;
      BValid = 1; BRD = 2'd0; BData = 16'h0002;
      step(0);
      chk("same_rd_first_a", obs_a, 1);
      AValid = 0;
      step(0);
      chk("same_rd_then_b", obs_b, 1);
      BValid = 0;
      step(0);
      step(0);
      chk("same_rd_final_r0", rf[0], 16'h0002);
      chk("alt_final_r1", rf[1], 16'hAAAA);
      chk("alt_final_r3", rf[3], 16'h5555);

      // Idle: nothing written, and the favoured requester (A) is kept.
      for (int i = 0; i < 3; i++) begin
         step(0);
         chk("idle_regwrite", RegWrite, 0);
         chk("idle_no_ready", {obs_a, obs_b}, 0);
      end
      AValid = 1; ARD = 2'd2; AData = 16'h7777;
      BValid = 1; BRD = 2'd2; BData = 16'h8888;
      step(0);
      chk("idle_prio_kept", obs_a, 1);
      AValid = 0;
      step(0);
      BValid = 0;

      // Reset during RUN with a write pending on the outputs.
      AValid = 1; ARD = 2'd1; AData = 16'hBEEF;
      step(0);
      chk("pre_reset_write", RegWrite, 1);
      AValid = 0;
      step(1);
      chk("reset_drops_write", RegWrite, 0);
      chk("reset_clears_done", InitDone, 0);
      for (int i = 0; i < NREG; i++) begin
         step(0);
         chk("resweep_rd", RD, i);
         chk("resweep_done", InitDone, i == NREG - 1);
      end

      // Randomized traffic with occasional resets; requesters hold until granted.
      for (int n = 0; n < 400; n++) begin
         if (!AValid && $urandom_range(0, 2) != 0) begin
            AValid = 1; ARD = AW'($urandom); AData = DW'($urandom);
         end
         if (!BValid && $urandom_range(0, 2) != 0) begin
            BValid = 1; BRD = AW'($urandom); BData = DW'($urandom);
         end
         step($urandom_range(0, 59) == 0);
         if (obs_a && !Reset) AValid = 0;
         if (obs_b && !Reset) BValid = 0;
      end

      // Quiesce within a bounded number of cycles, then compare the register file.
      AValid = 0; BValid = 0;
      steps = 0;
      while ((m_sweep > 0 || m_we) && steps < 10) begin
         step(0);
         steps++;
      end
      step(0);
      chk("quiesce_in_time", steps < 10, 1);
      for (int i = 0; i < NREG; i++) chk("final_rf", rf[i], m_regs[i]);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
